// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - double-buffered multi-channel PWM LED driver with breathe mode
`timescale 1ns/1ps
module rgb_pwm #(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  // Prescaler width; a PRESCALE of 1 still gets a 1-bit counter that stays at 0.
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic             OFF      = (ACTIVE_LOW != 0);

  logic [PW-1:0]       pre;
  logic [WIDTH-1:0]    cnt;
  logic                tick;
  logic                boundary;
  logic [CHANNELS-1:0] mode;
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] on;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (cnt == CNT_MAX);

  // Prescaler and PWM counter; cnt advances once per tick and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Global mode and enable registers; they act on the very next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode   <= '0;
      enable <= '0;
    end else if (wr_en) begin
      if (wr_addr == 4'd8) mode   <= wr_data[CHANNELS-1:0];
      if (wr_addr == 4'd9) enable <= wr_data[CHANNELS-1:0];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] level;
    logic             dir;       // 0 = ramping up, 1 = ramping down
    logic [WIDTH-1:0] level_nx;
    logic             dir_nx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // One extra bit catches overflow of the ramp up and borrow of the ramp down.
    assign sum  = {1'b0, level} + {1'b0, shadow};
    assign diff = {1'b0, level} - {1'b0, shadow};

    // Next fade level: saturate at either end and reverse direction there.
    always_comb begin
      level_nx = level;
      dir_nx   = dir;
      if (!dir) begin
        if (sum >= {1'b0, CNT_MAX}) begin
          level_nx = CNT_MAX;
          dir_nx   = 1'b1;
        end else begin
          level_nx = sum[WIDTH-1:0];
        end
      end else begin
        if (diff[WIDTH] || (diff == '0)) begin
          level_nx = '0;
          dir_nx   = 1'b0;
        end else begin
          level_nx = diff[WIDTH-1:0];
        end
      end
    end

    // Shadow takes writes at any time; active only changes at the period
    // boundary, so a write landing on the boundary is seen one period later.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow <= '0;
        active <= '0;
        level  <= '0;
        dir    <= 1'b0;
      end else begin
        if (wr_en && (wr_addr == 4'(i))) shadow <= wr_data;
        if (boundary) begin
          if (mode[i]) begin
            active <= level_nx;
            level  <= level_nx;
            dir    <= dir_nx;
          end else begin
            active <= shadow;
            level  <= '0;
            dir    <= 1'b0;
          end
        end
      end
    end

    assign on[i] = enable[i] && (cnt < active);
  end

  // Output stage: registered, polarity-adjusted PWM and period pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out     <= {CHANNELS{OFF}};
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= on ^ {CHANNELS{OFF}};
      period_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_rgb_pwm.sv
// tb/tb_rgb_pwm.sv - randomized and directed self-checking bench for rgb_pwm
`timescale 1ns/1ps
module tb_rgb_pwm;
  localparam int CH     = 3;
  localparam int W      = 4;
  localparam int P      = 2;
  localparam int PERIOD = P * (1 << W);
  localparam int MAXV   = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  rgb_pwm #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(P), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time is the number of edges k since reset release.
  int            k;
  int            sh[CH];
  int            act[CH];
  int            lvl[CH];
  bit            dn[CH];
  int            md;
  int            en;
  logic [CH-1:0] exp_pwm;
  logic          exp_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    k = 0;
    md = 0;
    en = 0;
    for (int i = 0; i < CH; i++) begin
      sh[i] = 0; act[i] = 0; lvl[i] = 0; dn[i] = 0;
    end
  endtask

  task automatic model_edge(input logic we, input logic [3:0] a, input logic [W-1:0] d);
    int c;
    bit bnd;
    c   = (k / P) % (1 << W);
    bnd = (k % PERIOD) == PERIOD - 1;
    for (int i = 0; i < CH; i++)
      exp_pwm[i] = ((((en >> i) & 1) != 0) && (c < act[i])) ? 1'b0 : 1'b1;
    exp_tick = bnd;
    if (bnd) begin
      for (int i = 0; i < CH; i++) begin
        if (((md >> i) & 1) == 0) begin
          act[i] = sh[i]; lvl[i] = 0; dn[i] = 0;
        end else begin
          if (!dn[i]) begin
            lvl[i] = (lvl[i] + sh[i] > MAXV) ? MAXV : lvl[i] + sh[i];
            if (lvl[i] == MAXV) dn[i] = 1;
          end else begin
            lvl[i] = (lvl[i] - sh[i] < 0) ? 0 : lvl[i] - sh[i];
            if (lvl[i] == 0) dn[i] = 0;
          end
          act[i] = lvl[i];
        end
      end
    end
    if (we) begin
      if (int'(a) < CH) sh[a] = int'(d);
      else if (a == 4'd8) md = int'(d) & ((1 << CH) - 1);
      else if (a == 4'd9) en = int'(d) & ((1 << CH) - 1);
    end
    k++;
  endtask

  task automatic tick_once(input logic we, input logic [3:0] a, input logic [W-1:0] d);
    wr_en = we; wr_addr = a; wr_data = d;
    model_edge(we, a, d);
    @(posedge clk);
    #1;
    check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check("period_tick", 32'(period_tick), 32'(exp_tick));
    wr_en = 1'b0;
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    do begin
      tick_once(1'b0, 4'd0, '0);
      n++;
    end while (!exp_tick && n < 2 * PERIOD);
    if (!exp_tick) check("boundary_timeout", 0, 1);
  endtask

  task automatic measure_low(input int ch, input int wr_at, input logic [3:0] a,
                             input logic [W-1:0] d, output int lows);
    lows = 0;
    for (int j = 0; j < PERIOD; j++) begin
      if (j == wr_at) tick_once(1'b1, a, d);
      else tick_once(1'b0, 4'd0, '0);
      if (pwm_out[ch] == 1'b0) lows++;
    end
  endtask

  task automatic reset_mid();
    #2;
    reset = 1'b1;
    #1;
    check("rst_pwm", 32'(pwm_out), 32'd7);
    check("rst_tick", 32'(period_tick), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lows;
    int ticks;
    int brk[7];
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwm", 32'(pwm_out), 32'd7);
    check("reset_tick", 32'(period_tick), 32'd0);
    reset = 1'b0;

    // All enabled at zero duty: outputs stay off, one tick per period.
    tick_once(1'b1, 4'd9, 4'd7);
    wait_boundary();
    ticks = 0;
    for (int j = 0; j < 2 * PERIOD; j++) begin
      tick_once(1'b0, 4'd0, '0);
      if (period_tick) ticks++;
    end
    check("tick_count", ticks, 2);

    // Static duty 4 on channel 0.
    tick_once(1'b1, 4'd0, 4'd4);
    tick_once(1'b1, 4'd9, 4'd1);
    wait_boundary();
    measure_low(0, -1, 4'd0, '0, lows);
    check("duty4_low", lows, 8);

    // Mid-period write applies next period; boundary-coincident write one later.
    measure_low(0, 12, 4'd0, 4'd12, lows);
    check("midwr_cur", lows, 8);
    measure_low(0, -1, 4'd0, '0, lows);
    check("midwr_next", lows, 24);
    measure_low(0, PERIOD - 1, 4'd0, 4'd4, lows);
    check("coll_cur", lows, 24);
    measure_low(0, -1, 4'd0, '0, lows);
    check("coll_next", lows, 24);
    measure_low(0, -1, 4'd0, '0, lows);
    check("coll_later", lows, 8);

    // Full-scale and zero duty on channel 1.
    tick_once(1'b1, 4'd1, 4'd15);
    tick_once(1'b1, 4'd9, 4'd3);
    wait_boundary();
    measure_low(1, -1, 4'd0, '0, lows);
    check("duty15_low", lows, 30);
    tick_once(1'b1, 4'd1, 4'd0);
    wait_boundary();
    measure_low(1, -1, 4'd0, '0, lows);
    check("duty0_low", lows, 0);

    // Breathe on channel 1 with step 5: actives 5,10,15,10,5,0,5.
    brk = '{5, 10, 15, 10, 5, 0, 5};
    tick_once(1'b1, 4'd1, 4'd5);
    tick_once(1'b1, 4'd8, 4'd2);
    wait_boundary();
    for (int p = 0; p < 7; p++) begin
      measure_low(1, -1, 4'd0, '0, lows);
      check($sformatf("breathe_%0d", p), lows, 2 * brk[p]);
    end
    tick_once(1'b1, 4'd8, 4'd0);
    wait_boundary();
    measure_low(1, -1, 4'd0, '0, lows);
    check("static_again", lows, 10);
    tick_once(1'b1, 4'd8, 4'd2);
    wait_boundary();
    measure_low(1, -1, 4'd0, '0, lows);
    check("level_cleared", lows, 10);

    // Clearing enable mid-pulse: output releases on the second edge.
    tick_once(1'b1, 4'd8, 4'd0);
    tick_once(1'b1, 4'd0, 4'd12);
    tick_once(1'b1, 4'd9, 4'd1);
    wait_boundary();
    repeat (4) tick_once(1'b0, 4'd0, '0);
    tick_once(1'b1, 4'd9, 4'd0);
    check("en_hold", 32'(pwm_out[0]), 32'd0);
    tick_once(1'b0, 4'd0, '0);
    check("en_off", 32'(pwm_out[0]), 32'd1);

    // Randomized register traffic against the model.
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 3) == 0)
        tick_once(1'b1, 4'($urandom_range(0, 15)), W'($urandom));
      else
        tick_once(1'b0, 4'd0, '0);
    end

    // Asynchronous reset while outputs are driving.
    tick_once(1'b1, 4'd8, 4'd0);
    for (int i = 0; i < CH; i++) tick_once(1'b1, 4'(i), 4'd10);
    tick_once(1'b1, 4'd9, 4'd7);
    wait_boundary();
    repeat (3) tick_once(1'b0, 4'd0, '0);
    check("pre_reset_on", 32'(pwm_out), 32'd0);
    reset_mid();
    check("post_reset_pwm", 32'(pwm_out), 32'd7);
    repeat (PERIOD + 4) tick_once(1'b0, 4'd0, '0);

    // Asynchronous reset in the cycle period_tick is high.
    tick_once(1'b1, 4'd9, 4'd7);
    wait_boundary();
    reset_mid();
    repeat (PERIOD + 4) tick_once(1'b0, 4'd0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm.md
# rgb_pwm

Parametrised multi-channel PWM LED driver that replaces direct GPIO-to-LED wiring on the ice40 board tops. It sits between the `avr_soc` I/O bus and the RGB LED pins. Per-channel duty registers are double-buffered so updates never glitch a period. An optional per-channel "breathe" mode ramps brightness automatically, with no CPU involvement.

## Interface
Parameters:
- `CHANNELS`, default 3: number of PWM outputs, 1..8.
- `WIDTH`, default 8: PWM resolution in bits, 4..16. Constraint: `WIDTH >= CHANNELS`.
- `PRESCALE`, default 16: `clk` cycles per PWM count, at least 1.
- `ACTIVE_LOW`, default 1: when 1, outputs are inverted (LED on = 0).

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  register write strobe, sampled on the rising edge of `clk`.
- `wr_addr`  in  4  register address.
- `wr_data`  in  WIDTH  register write data.
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `period_tick`  out  1  one-cycle pulse at each PWM period boundary.

## Operation
- Register map:
  - 0..CHANNELS-1: `shadow[i]`. This is the duty in static mode and the step size in breathe mode.
  - 8: `mode`, low CHANNELS bits; 1 = breathe.
  - 9: `enable`, low CHANNELS bits.
  - All other addresses, including CHANNELS..7, are ignored.
- Prescaler `pre` counts 0..PRESCALE-1. `tick` is asserted in the cycle where `pre == PRESCALE-1`.
- Counter `cnt` is WIDTH bits. It increments on `tick` and wraps from 2^WIDTH-1 to 0.
- `boundary` = `tick && cnt == 2^WIDTH-1`. At the same edge:
  - `cnt` wraps to 0.
  - `active[i]` is loaded.
  - `period_tick` is registered high for exactly one cycle.
- Loading `active[i]` at the boundary:
  - mode bit 0: `active[i] <= shadow[i]`, then `level[i] <= 0` and `dir[i] <= up`.
  - mode bit 1: `active[i] <= level_next[i]` and `level[i] <= level_next[i]`.
- Write/boundary collision: a duty write in the same cycle as `boundary` updates `shadow` only. `active` takes the pre-write `shadow`, and the new value applies from the following boundary.
- Breathe arithmetic uses a WIDTH+1-bit sum/difference.
  - up: `level_next = min(level + step, 2^WIDTH-1)`. Reaching the max sets `dir` to down.
  - down: `level_next = max(level - step, 0)`. Reaching 0 sets `dir` to up.
  - Step 0 holds the level constant.
- Output: `on[i] = enable[i] && (cnt < active[i])`. `pwm_out[i] <= on[i] ^ ACTIVE_LOW` (registered).
  - Duty 0 means never on.
  - Duty 2^WIDTH-1 means on for 2^WIDTH-1 of 2^WIDTH counts.
- Disabling a channel forces its output inactive. Fade state (`level`, `dir`) keeps running at boundaries.
- `mode` and `enable` writes take effect on the next edge. A mode change affects duty only from the next boundary.
- Reset values (asynchronous):
  - `pre = 0`, `cnt = 0`.
  - `shadow`, `active`, `level` = 0; `dir` = up.
  - `mode` = 0, `enable` = 0.
  - `period_tick` = 0.
  - `pwm_out` = all bits equal to ACTIVE_LOW, i.e. all LEDs off.

## Timing
- PWM period = PRESCALE × 2^WIDTH cycles. With PRESCALE = 1, `tick` is asserted every cycle.
- `pwm_out` lags `cnt`/`active` by one register stage. On-time per period = `active[i]` × PRESCALE cycles.
- Write to `enable`: `pwm_out` responds on the second rising edge after the write cycle (the register updates, then the output registers).
- Duty write latency: the new duty is visible from the first full period after the next boundary, never mid-period.
- Reset asserted mid-period clears all state immediately, without waiting for a clock edge. After release, counting restarts from `pre = 0`, `cnt = 0`.

## Test plan
All scenarios use CHANNELS=3, WIDTH=4, PRESCALE=2, ACTIVE_LOW=1, giving a 32-cycle period.
- Reset, then write `enable=3'b111` with all duties 0 -> `pwm_out` stays 3'b111 indefinitely. `period_tick` pulses every 32 cycles, for 1 cycle each.
- Write `shadow0=4` and `enable=3'b001` -> from the first full period after the next boundary, `pwm_out[0]` is low for 8 cycles then high for 24, repeating. Bits 1 and 2 stay high.
- While `shadow0=4`, write `shadow0=12` when `cnt=6` -> the current period stays at 8 low cycles; the next period has 24 low cycles. Repeat the write coincident with `boundary` -> a 12-duty period appears one period later.
- `shadow1=15` with `enable` bit 1 -> 30 low / 2 high cycles per period. `shadow1=0` -> never low.
- `mode=3'b010`, `shadow1=5` -> successive `active[1]` values are 5, 10, 15, 10, 5, 0, 5. Setting mode back to 0 -> next `active[1]` equals `shadow1`, and `level` is cleared.
- Assert `reset` asynchronously mid-period with the PWM running -> `pwm_out=3'b111` and `period_tick=0` before the next clock edge. Separately, clear an enable bit mid-pulse -> that output goes high 2 edges after the write cycle.
